// File: rtl/dmem_access_unit_if.sv
// Bundle of the MEM-stage request/response signals and the data-memory port
// driven by dmem_access_unit. slave = the access unit, master = its environment.
interface dmem_access_unit_if;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic        mem_WE;
  logic [31:0] mem_WA;
  logic [31:0] mem_WD;
  logic [31:0] mem_RD;

  // Handshake: a request is taken on a rising clk edge where req=1 and ready=1;
  // req while ready=0 is dropped. done pulses for one cycle per accepted request,
  // with err and rdata valid in that same cycle.
  modport slave (
    input  req, we, size, sign_ext, addr, wdata, mem_RD,
    output ready, done, err, rdata, mem_WE, mem_WA, mem_WD
  );

  modport master (
    output req, we, size, sign_ext, addr, wdata, mem_RD,
    input  ready, done, err, rdata, mem_WE, mem_WA, mem_WD
  );
endinterface

// File: rtl/dmem_access_unit.sv
// Byte-addressed load/store initiator for a word-only data memory: extracts and
// extends sub-word loads, and performs sb/sh as read-modify-write.
module dmem_access_unit #(
  parameter int MEM_WORDS = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dmem_access_unit_if.slave    bus,
  output logic [2:0]           dbg_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RMW_RD = 3'd2,
    WRITE  = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [31:0] WORD_LIMIT = 32'(MEM_WORDS);

  state_t      state;
  logic        sx_q;
  logic [1:0]  size_q;
  logic [1:0]  off_q;
  logic [31:0] wdata_q;

  logic        req_bad;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] load_val;
  logic [31:0] merged;

  assign dbg_state = state;

  always_comb begin
    req_bad = (bus.size == 2'b11)
           || (bus.size == 2'b01 && bus.addr[0])
           || (bus.size == 2'b10 && bus.addr[1:0] != 2'b00)
           || ({2'b00, bus.addr[31:2]} >= WORD_LIMIT);
  end

  // Lane select/merge works on the word currently addressed by mem_WA.
  always_comb begin
    sel_byte = 8'h00;
    merged   = bus.mem_RD;
    case (off_q)
      2'd0: begin sel_byte = bus.mem_RD[7:0];   merged[7:0]   = wdata_q[7:0]; end
      2'd1: begin sel_byte = bus.mem_RD[15:8];  merged[15:8]  = wdata_q[7:0]; end
      2'd2: begin sel_byte = bus.mem_RD[23:16]; merged[23:16] = wdata_q[7:0]; end
      default: begin sel_byte = bus.mem_RD[31:24]; merged[31:24] = wdata_q[7:0]; end
    endcase
    sel_half = off_q[1] ? bus.mem_RD[31:16] : bus.mem_RD[15:0];
    if (size_q == 2'b01) begin
      merged = bus.mem_RD;
      if (off_q[1]) merged[31:16] = wdata_q[15:0];
      else          merged[15:0]  = wdata_q[15:0];
    end
    case (size_q)
      2'b00:   load_val = {{24{sx_q & sel_byte[7]}}, sel_byte};
      2'b01:   load_val = {{16{sx_q & sel_half[15]}}, sel_half};
      default: load_val = bus.mem_RD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bus.ready  <= 1'b1;
      bus.done   <= 1'b0;
      bus.err    <= 1'b0;
      bus.rdata  <= 32'h0;
      bus.mem_WE <= 1'b0;
      bus.mem_WA <= 32'h0;
      bus.mem_WD <= 32'h0;
      sx_q       <= 1'b0;
      size_q     <= 2'b00;
      off_q      <= 2'b00;
      wdata_q    <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req) begin
            sx_q       <= bus.sign_ext;
            size_q     <= bus.size;
            off_q      <= bus.addr[1:0];
            wdata_q    <= bus.wdata;
            bus.mem_WA <= {2'b00, bus.addr[31:2]};
            bus.ready  <= 1'b0;
            if (req_bad) begin
              state    <= DONE;
              bus.done <= 1'b1;
              bus.err  <= 1'b1;
            end else if (!bus.we) begin
              state <= LOAD;
            end else if (bus.size == 2'b10) begin
              state      <= WRITE;
              bus.mem_WE <= 1'b1;
              bus.mem_WD <= bus.wdata;
            end else begin
              state <= RMW_RD;
            end
          end
        end
        LOAD: begin
          bus.rdata <= load_val;
          bus.done  <= 1'b1;
          state     <= DONE;
        end
        RMW_RD: begin
          bus.mem_WD <= merged;
          bus.mem_WE <= 1'b1;
          state      <= WRITE;
        end
        WRITE: begin
          bus.mem_WE <= 1'b0;
          bus.done   <= 1'b1;
          state      <= DONE;
        end
        DONE: begin
          bus.done  <= 1'b0;
          bus.err   <= 1'b0;
          bus.ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          bus.mem_WE <= 1'b0;
          bus.done   <= 1'b0;
          bus.err    <= 1'b0;
          bus.ready  <= 1'b1;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit with a 1024-word memory model.
module tb_dmem_access_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] dbg_state;

  dmem_access_unit_if bus ();

  dmem_access_unit #(.MEM_WORDS(1024)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // Memory model: combinational read, write on rising edge; poke port for preload.
  logic [31:0] mem [0:1023];
  logic        poke_en = 1'b0;
  logic [9:0]  poke_idx = '0;
  logic [31:0] poke_val = '0;

  assign bus.mem_RD = (bus.mem_WA < 32'd1024) ? mem[bus.mem_WA[9:0]] : 32'h0;

  always @(posedge clk) begin
    if (poke_en) mem[poke_idx] <= poke_val;
    else if (bus.mem_WE && bus.mem_WA < 32'd1024) mem[bus.mem_WA[9:0]] <= bus.mem_WD;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic poke(input int idx, input logic [31:0] val);
    @(negedge clk);
    poke_en  = 1'b1;
    poke_idx = idx[9:0];
    poke_val = val;
    @(posedge clk);
    #1 poke_en = 1'b0;
  endtask

  int          r_lat, r_we_cnt, r_we_cyc;
  logic        r_err;
  logic [31:0] r_rdata, r_we_wa, r_we_wd;

  // Issue one request and watch up to 8 cycles; cycle numbers count the accept edge as 0.
  task automatic do_req(input logic w, input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    chk("ready_before_req", {31'b0, bus.ready}, 32'd1);
    bus.req = 1'b1; bus.we = w; bus.size = sz; bus.sign_ext = sx;
    bus.addr = a; bus.wdata = d;
    @(posedge clk);
    r_lat = 0; r_we_cnt = 0; r_we_cyc = 0; r_err = 1'b0;
    r_rdata = 32'h0; r_we_wa = 32'h0; r_we_wd = 32'h0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) bus.req = 1'b0;
      if (bus.mem_WE) begin
        r_we_cnt++; r_we_cyc = c; r_we_wa = bus.mem_WA; r_we_wd = bus.mem_WD;
      end
      if (bus.done) begin
        r_lat = c; r_err = bus.err; r_rdata = bus.rdata;
        break;
      end
    end
  endtask

  task automatic load_chk(input string tag, input logic [1:0] sz, input logic sx,
                          input logic [31:0] a, input logic [31:0] exp);
    do_req(1'b0, sz, sx, a, 32'h0);
    chk({tag, "_lat"}, r_lat, 32'd2);
    chk({tag, "_err"}, {31'b0, r_err}, 32'd0);
    chk({tag, "_rdata"}, r_rdata, exp);
    chk({tag, "_no_we"}, r_we_cnt, 32'd0);
  endtask

  task automatic err_chk(input string tag, input logic w, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] exp_rdata);
    do_req(w, sz, 1'b0, a, 32'hFFFF_FFFF);
    chk({tag, "_lat"}, r_lat, 32'd1);
    chk({tag, "_err"}, {31'b0, r_err}, 32'd1);
    chk({tag, "_no_we"}, r_we_cnt, 32'd0);
    chk({tag, "_rdata_held"}, r_rdata, exp_rdata);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int acc, dn, wes;

  initial begin
    bus.req = 1'b0; bus.we = 1'b0; bus.size = 2'b00; bus.sign_ext = 1'b0;
    bus.addr = 32'h0; bus.wdata = 32'h0;

    // Reset values while rst_n is low.
    #12;
    chk("rst_ready", {31'b0, bus.ready}, 32'd1);
    chk("rst_done",  {31'b0, bus.done},  32'd0);
    chk("rst_err",   {31'b0, bus.err},   32'd0);
    chk("rst_we",    {31'b0, bus.mem_WE}, 32'd0);
    chk("rst_rdata", bus.rdata,  32'h0);
    chk("rst_wa",    bus.mem_WA, 32'h0);
    chk("rst_wd",    bus.mem_WD, 32'h0);
    chk("rst_state", {29'b0, dbg_state}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Loads.
    poke(0, 32'h0000_0001);
    poke(5, 32'h0000_80FF);
    load_chk("lw0",   2'b10, 1'b1, 32'h0,  32'h0000_0001);
    load_chk("lb15",  2'b00, 1'b1, 32'h15, 32'hFFFF_FF80);
    load_chk("lbu15", 2'b00, 1'b0, 32'h15, 32'h0000_0080);
    load_chk("lh14",  2'b01, 1'b1, 32'h14, 32'hFFFF_80FF);
    load_chk("lhu14", 2'b01, 1'b0, 32'h14, 32'h0000_80FF);
    load_chk("lhu16", 2'b01, 1'b0, 32'h16, 32'h0000_0000);
    load_chk("lb14",  2'b00, 1'b1, 32'h14, 32'hFFFF_FFFF);

    // sb: read-modify-write of byte 2.
    poke(5, 32'h1122_3344);
    do_req(1'b1, 2'b00, 1'b0, 32'h16, 32'hDEAD_BEAB);
    chk("sb_we_cnt", r_we_cnt, 32'd1);
    chk("sb_we_cyc", r_we_cyc, 32'd2);
    chk("sb_wa",     r_we_wa,  32'd5);
    chk("sb_wd",     r_we_wd,  32'h11AB_3344);
    chk("sb_lat",    r_lat,    32'd3);
    chk("sb_err",    {31'b0, r_err}, 32'd0);
    chk("sb_rdata_held", r_rdata, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("sb_mem", mem[5], 32'h11AB_3344);

    // sh: upper half; sb byte 0.
    do_req(1'b1, 2'b01, 1'b0, 32'h16, 32'h0000_CAFE);
    chk("sh_we_cyc", r_we_cyc, 32'd2);
    chk("sh_wd",     r_we_wd,  32'hCAFE_3344);
    chk("sh_lat",    r_lat,    32'd3);
    do_req(1'b1, 2'b00, 1'b0, 32'h14, 32'h0000_0077);
    chk("sb0_wd",    r_we_wd,  32'hCAFE_3377);

    // sw: write in cycle 1, done in cycle 2.
    do_req(1'b1, 2'b10, 1'b0, 32'h18, 32'h1234_5678);
    chk("sw_we_cnt", r_we_cnt, 32'd1);
    chk("sw_we_cyc", r_we_cyc, 32'd1);
    chk("sw_wa",     r_we_wa,  32'd6);
    chk("sw_wd",     r_we_wd,  32'h1234_5678);
    chk("sw_lat",    r_lat,    32'd2);
    @(negedge clk);
    chk("sw_mem", mem[6], 32'h1234_5678);
    chk("sw_mem5_keep", mem[5], 32'hCAFE_3377);

    // Errors: rdata keeps the last load result.
    err_chk("err_sh3",    1'b1, 2'b01, 32'h3,    32'hFFFF_FFFF);
    err_chk("err_lw2",    1'b0, 2'b10, 32'h2,    32'hFFFF_FFFF);
    err_chk("err_sw1000", 1'b1, 2'b10, 32'h1000, 32'hFFFF_FFFF);
    err_chk("err_size3",  1'b0, 2'b11, 32'h0,    32'hFFFF_FFFF);
    @(negedge clk);
    chk("err_mem0_keep", mem[0], 32'h0000_0001);

    // Last in-range word.
    poke(1023, 32'hA0B0_C0D0);
    load_chk("lw_top", 2'b10, 1'b0, 32'hFFC, 32'hA0B0_C0D0);

    // req held high: sw every 3 cycles, accepts at negedges 0,3,6,9.
    acc = 0; dn = 0; wes = 0;
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b1; bus.size = 2'b10; bus.addr = 32'h1C;
    bus.wdata = 32'hA5A5_A5A5;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 12) bus.req = 1'b0;
      if (bus.req && bus.ready) acc++;
      if (bus.done) dn++;
      if (bus.mem_WE) wes++;
    end
    chk("busy_accepts", acc, 32'd4);
    chk("busy_dones",   dn,  32'd4);
    chk("busy_writes",  wes, 32'd4);
    chk("busy_mem", mem[7], 32'hA5A5_A5A5);

    // Reset during RMW_RD of sb.
    poke(8, 32'h5566_7788);
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b1; bus.size = 2'b00; bus.addr = 32'h20; bus.wdata = 32'hAA;
    @(posedge clk);
    @(negedge clk);
    bus.req = 1'b0;
    chk("rmw_state", {29'b0, dbg_state}, 32'd2);
    rst_n = 1'b0;
    #1;
    chk("rmw_rst_we", {31'b0, bus.mem_WE}, 32'd0);
    dn = 0; wes = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (bus.done) dn++;
      if (bus.mem_WE) wes++;
    end
    rst_n = 1'b1;
    @(negedge clk);
    if (bus.done) dn++;
    if (bus.mem_WE) wes++;
    chk("rmw_rst_ready", {31'b0, bus.ready}, 32'd1);
    chk("rmw_rst_no_done", dn, 32'd0);
    chk("rmw_rst_no_we", wes, 32'd0);
    chk("rmw_rst_mem", mem[8], 32'h5566_7788);

    // Reset during WRITE of sw: mem_WE drops without waiting for clk.
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b1; bus.size = 2'b10; bus.addr = 32'h24; bus.wdata = 32'h0BAD_F00D;
    @(posedge clk);
    @(negedge clk);
    bus.req = 1'b0;
    chk("wr_in_write", {31'b0, bus.mem_WE}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("wr_rst_we", {31'b0, bus.mem_WE}, 32'd0);
    chk("wr_rst_done", {31'b0, bus.done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("wr_rst_ready", {31'b0, bus.ready}, 32'd1);
    chk("wr_rst_done2", {31'b0, bus.done}, 32'd0);

    // Unit still works after reset.
    load_chk("post_rst_lw", 2'b10, 1'b0, 32'h18, 32'h1234_5678);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_access_unit.md
Name: dmem_access_unit

Overview:
- Load/store initiator that drives the word-addressed data memory on behalf of the processor's MEM stage.
- Converts byte-addressed lb/lbu/lh/lhu/lw/sb/sh/sw requests into word accesses.
- Byte and halfword loads are extracted and extended.
- The memory only writes whole words, so sb/sh are done as read-modify-write.

Parameters:
MEM_WORDS, 1024, number of 32-bit words in the attached data memory; word indices >= MEM_WORDS are out of range.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous reset, active low
req  in  1  request strobe; sampled only when ready=1
we  in  1  1=store, 0=load
size  in  2  00=byte, 01=half, 10=word, 11=illegal
sign_ext  in  1  loads only: 1=sign-extend, 0=zero-extend
addr  in  32  byte address
wdata  in  32  store data; byte/half taken from low bits
ready  out  1  unit idle and able to accept req
done  out  1  one-cycle completion pulse
err  out  1  valid with done; request was misaligned, illegal size or out of range
rdata  out  32  load result; valid with done, held until the next done
mem_WE  out  1  memory write enable
mem_WA  out  32  memory word index, equal to addr[31:2]
mem_WD  out  32  memory write data
mem_RD  in  32  memory read data; combinational from mem_WA

Behaviour:
- Reset, asynchronous, rst_n=0:
  - State goes to IDLE.
  - ready=1; done=0, err=0.
  - rdata, mem_WA and mem_WD are 0.
  - mem_WE=0 immediately, with no dependence on clk.
- States: IDLE, LOAD, RMW_RD, WRITE, DONE.
- IDLE, on req=1 at a clock edge:
  - Latch addr, we, size, sign_ext, wdata.
  - Load mem_WA register with addr[31:2].
- Errors: size=11, half with addr[0]=1, word with addr[1:0]!=0, or addr[31:2] >= MEM_WORDS.
  - Go to DONE with err=1.
  - No memory write; rdata unchanged.
- Next state from IDLE for legal requests:
  - Load -> LOAD.
  - sw -> WRITE with mem_WD=wdata.
  - sb/sh -> RMW_RD.
- LOAD:
  - Capture mem_RD and select the byte/half by addr[1:0].
  - Little-endian: byte k is bits 8k+7:8k; half at addr[1]=1 is bits 31:16.
  - Extend per sign_ext; lw ignores sign_ext.
  - Register the result into rdata; go to DONE.
- RMW_RD:
  - Capture mem_RD and replace only the addressed byte/half with the low bits of wdata.
  - Store the merged word into mem_WD; go to WRITE.
- WRITE: mem_WE=1 for exactly this one cycle; go to DONE.
- DONE: done=1 (err as decided); go to IDLE.
- mem_WE=1 only in WRITE. mem_WA holds stable from acceptance through DONE.
- ready=1 only in IDLE. A req while ready=0 is ignored, not queued.
- Latency, counting the accept edge as edge 0:
  - Error: done in cycle 1.
  - Load: done in cycle 2.
  - sw: write in cycle 1, done in cycle 2.
  - sb/sh: write in cycle 2, done in cycle 3.
- Back-to-back: a new req is accepted in the cycle after DONE. Throughput is 1 access per 3 cycles for loads and sw.
- Reset asserted mid-operation, including during WRITE: the operation is abandoned with no done pulse. For RMW interrupted before WRITE, memory is unchanged.

Test Plan:
- lw: mem[0]=1, req lw addr 0x0 -> done 2 cycles after accept, rdata=0x00000001, err=0, mem_WE never high.
- lb/lbu: mem[5]=0x000080FF.
  - lb addr 0x15 -> rdata=0xFFFFFF80.
  - lbu addr 0x15 -> 0x00000080.
  - lh addr 0x14 signed -> 0xFFFF80FF.
- sb: mem[5]=0x11223344, sb wdata=0xDEADBEAB addr 0x16 -> exactly one mem_WE cycle, 2 cycles after accept, with mem_WA=5 and mem_WD=0x11AB3344; mem[5]=0x11AB3344 afterwards.
- Errors, each giving done=1 and err=1 one cycle after accept with no mem_WE:
  - sh addr 0x3.
  - lw addr 0x2.
  - sw addr 0x1000 (index 1024).
  - size=11.
- Busy and reset:
  - req held high continuously -> accepts only in IDLE, one done per accepted request, no lost or duplicated writes.
  - rst_n low during RMW_RD of sb -> mem_WE stays 0, memory unchanged, ready=1 after release.
